// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller: access sizes and FSM states.
package dm_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/dm_access_ctrl_lane_align.sv
// Combinational lane handling: merges store data into a read word and extracts/extends load data.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] data,
   output logic [31:0] merged,
   output logic [31:0] extracted
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = word[{lane, 3'b000} +: 8];
      half_v    = lane[1] ? word[31:16] : word[15:0];
      merged    = data;
      extracted = word;
      case (size)
         SZ_BYTE: begin
            merged = word;
            merged[{lane, 3'b000} +: 8] = data[7:0];
            extracted = {{24{sext & byte_v[7]}}, byte_v};
         end
         SZ_HALF: begin
            merged = word;
            if (lane[1]) merged[31:16] = data[15:0];
            else         merged[15:0]  = data[15:0];
            extracted = {{16{sext & half_v[15]}}, half_v};
         end
         default: begin
            merged    = data;
            extracted = word;
         end
      endcase
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// CPU-side data-memory initiator: multi-cycle loads, stores and read-modify-write sub-word stores.
//  state | meaning
//  IDLE  | waiting for req; request fields captured on acceptance
//  RD    | reading aligned word; loads finish here, sb/sh build merged word
//  WR    | dm_w_ena high for one cycle, memory writes on the negedge
//  DONE  | done pulse (err valid), req ignored
module dm_access_ctrl
   import dm_pkg::*;
#(
   parameter int unsigned DM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        dm_w_ena,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata
);

   localparam logic [31:0] LIM_B = 32'(DM_BYTES - 1);
   localparam logic [31:0] LIM_H = 32'(DM_BYTES - 2);
   localparam logic [31:0] LIM_W = 32'(DM_BYTES - 4);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;

   logic        out_of_range;
   logic        req_err;
   logic [31:0] merged;
   logic [31:0] extracted;

   dm_lane_align u_lane_align (
      .size      (size_q),
      .sext      (sext_q),
      .lane      (addr_q[1:0]),
      .word      (dm_rdata),
      .data      (wdata_q),
      .merged    (merged),
      .extracted (extracted)
   );

   // Checked on the live request inputs so an error finishes in a single cycle.
   always_comb begin
      out_of_range = 1'b0;
      case (size)
         SZ_BYTE: out_of_range = addr > LIM_B;
         SZ_HALF: out_of_range = addr > LIM_H;
         SZ_WORD: out_of_range = addr > LIM_W;
         default: out_of_range = 1'b0;
      endcase
      req_err = (size == 2'b11)
              | ((size == SZ_HALF) & addr[0])
              | ((size == SZ_WORD) & (|addr[1:0]))
              | out_of_range;
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      sext_d     = sext_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      dm_wdata_d = dm_wdata_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               size_d  = size;
               sext_d  = sext;
               addr_d  = addr;
               wdata_d = wdata;
               if (req_err) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (we && (size == SZ_WORD)) begin
                  state_d    = WR;
                  dm_wdata_d = wdata;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (we_q) begin
               state_d    = WR;
               dm_wdata_d = merged;
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
               rdata_d = extracted;
            end
         end
         WR: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         sext_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         dm_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
         dm_wdata_q <= dm_wdata_d;
      end
   end

   // Reset gates the enable directly so a reset landing in WR blocks that negedge write.
   assign dm_w_ena = (state_q == WR) & ~rst;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign dm_addr  = {addr_q[31:2], 2'b00};
   assign dm_wdata = dm_wdata_q;

endmodule
